clock_timekeeper: RTL and testbench
===================================

# clock_timekeeper

Parametrised time-of-day core for the VGA clock designs: keeps hours/minutes/seconds in BCD, debounces the three adjust buttons with hold-to-repeat, and supports 12/24-hour display. It sits between the top-level input pins and the VGA renderer, which only reads its registered BCD outputs. Unlike the previous hard-coded counter, it is generic in clock frequency and debounce/repeat timing and adds a run gate and 12h mode.

## Interface

- CLK_HZ, 31_500_000: input clock frequency; one second = CLK_HZ cycles.
- DEBOUNCE_CYC, CLK_HZ/100: cycles a synchronised button level must stay stable before it is accepted.
- REPEAT_DELAY_CYC, CLK_HZ/2: hold time after the first event before auto-repeat starts.
- REPEAT_PERIOD_CYC, CLK_HZ/8: interval between auto-repeat events.

- clk  in  1  the block's single clock.
- reset  in  1  synchronous reset, active-high.
- adj_hrs  in  1  raw button, asynchronous; increments hours.
- adj_min  in  1  raw button, asynchronous; increments minutes.
- adj_sec  in  1  raw button, asynchronous; zeroes seconds and the prescaler.
- run  in  1  1 = time advances; 0 = prescaler frozen, adjusts still work.
- mode_12h  in  1  0 = 24h display, 1 = 12h display.
- hrs_bcd  out  6  [5:4] tens, [3:0] units of the displayed hour.
- min_bcd  out  7  [6:4] tens, [3:0] units.
- sec_bcd  out  7  [6:4] tens, [3:0] units.
- pm  out  1  1 when the internal hour is 12–23, in both modes.
- sec_tick  out  1  one-cycle pulse, coincident with the cycle the seconds value changes because of a prescaler wrap.

## Operation

- Internal time is always 24h BCD: hours 00–23, minutes and seconds 00–59.
- Prescaler counts 0..CLK_HZ-1 while run=1. On a wrap, seconds increment with BCD carry 59→00, then minutes, then hours 23→00.
- Each button passes through `adj_button`:
  - 2-flop synchroniser.
  - Debounce counter: the accepted level changes only after DEBOUNCE_CYC consecutive equal samples.
  - Event pulse on the accepted rising edge.
  - While the button is held: a further event after REPEAT_DELAY_CYC, then one every REPEAT_PERIOD_CYC.
  - Release stops repeat immediately.
- adj_hrs event: hours +1 mod 24. No effect on minutes or seconds.
- adj_min event: minutes +1 mod 60. No carry into hours.
- adj_sec event: seconds ← 00 and prescaler ← 0. Time does not advance in that cycle.
- Simultaneous events in one cycle:
  - Adjust and tick: adj_sec suppresses the tick and sec_tick. For adj_hrs/adj_min, the seconds tick still applies, but any carry into the field being adjusted is discarded and the adjust result wins.
  - Several buttons: all are applied independently.
- 12h display conversion (combinational on registered state, registered at output):
  - Hour 00 → 12.
  - Hours 01–12 unchanged.
  - Hours 13–23 → hour −12.
  - pm is unaffected by the mode.
- mode_12h and run may change at any time. A mode change affects only hrs_bcd, from the next cycle.

## Timing

- All outputs are registered.
- Reset values: time 00:00:00, prescaler 0, all debouncers idle with accepted level 0, sec_tick 0, pm 0.
  - hrs_bcd = 00 with mode_12h=0.
  - hrs_bcd = 12 one cycle after reset with mode_12h=1.
- Reset mid-debounce or mid-repeat returns the debouncer to idle. A button still held after reset produces a fresh first event after 2 + DEBOUNCE_CYC cycles.
- Tick latency: first sec_tick comes CLK_HZ cycles after reset release with run=1. The period is exactly CLK_HZ cycles.
- Adjust latency: the time change is visible 2 (sync) + DEBOUNCE_CYC + 1 cycles after a clean edge on the raw pin.
- run=0 holds the prescaler value; resuming continues from it, so no partial second is lost.

## Structure

- Package `clock_timekeeper_pkg`:
  - BCD field widths (6/7/7).
  - Limits 23/59.
  - BCD increment-with-wrap function returning {carry, next}.
  - 24h→12h conversion function.
- Sub-module `adj_button`: sync, debounce and repeat, parametrised by DEBOUNCE_CYC, REPEAT_DELAY_CYC and REPEAT_PERIOD_CYC. It is instanced three times.
- Top level holds the prescaler, the time registers and the output registers.

## Test plan

All scenarios use CLK_HZ=10, DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=5.

- Reset, run=1, 600 cycles → sec_tick every 10 cycles; time 00:01:00 after 600 cycles; min_bcd=0x01, sec_bcd=0x00.
- Preload 23:59:59 via adjusts, one tick → 00:00:00, pm 1→0, mode_12h=1 shows hrs_bcd=0x12.
- adj_min glitch of 3 cycles → no change. Clean press held 40 cycles → events at 7, 27, 32, 37 cycles after the edge (+1 each); release stops repeat.
- adj_sec pressed on the same cycle the prescaler wraps → seconds 00, no sec_tick, next tick 10 cycles later.
- Hours 13 with mode_12h toggled 0→1 → hrs_bcd 0x13 → 0x01 next cycle, pm=1 throughout. Hours 12 → 0x12 in both modes.
- run=0 for 37 cycles mid-second, then reset asserted while adj_hrs is held → all outputs return to reset values; the held button gives one event 6 cycles after reset release.

Source files
------------

// File: rtl/clock_timekeeper_pkg.sv
// Shared widths, limits and BCD helpers for the time-of-day core.
package clock_timekeeper_pkg;

    localparam int HRS_W = 6;
    localparam int MIN_W = 7;
    localparam int SEC_W = 7;

    localparam logic [7:0] HRS_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] SEC_MAX = 8'h59;

    // Two-digit BCD increment; returns {carry, next} and wraps to 00 after limit.
    function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] limit);
        logic [8:0] res;
        if (val == limit) begin
            res = 9'h100;
        end else if (val[3:0] == 4'd9) begin
            res = {1'b0, val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {1'b0, val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    function automatic logic [HRS_W-1:0] to_12h(input logic [HRS_W-1:0] hrs);
        logic [HRS_W-1:0] res;
        case (hrs)
            6'h00:   res = 6'h12;
            6'h13:   res = 6'h01;
            6'h14:   res = 6'h02;
            6'h15:   res = 6'h03;
            6'h16:   res = 6'h04;
            6'h17:   res = 6'h05;
            6'h18:   res = 6'h06;
            6'h19:   res = 6'h07;
            6'h20:   res = 6'h08;
            6'h21:   res = 6'h09;
            6'h22:   res = 6'h10;
            6'h23:   res = 6'h11;
            default: res = hrs;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/clock_timekeeper_adj_button.sv
// Adjust button front end: 2-flop sync, debounce, first-press event and hold-to-repeat.
module adj_button #(
    parameter int DEBOUNCE_CYC      = 4,
    parameter int REPEAT_DELAY_CYC  = 20,
    parameter int REPEAT_PERIOD_CYC = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RP_W-1:0] PER_LAST   = RP_W'(REPEAT_PERIOD_CYC - 1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            event_r;
    logic            rp_armed_r;
    logic [DB_W-1:0] db_cnt_r;
    logic [RP_W-1:0] rp_cnt_r;
    logic [RP_W-1:0] rp_last_s;

    assign rp_last_s = rp_armed_r ? PER_LAST : DELAY_LAST;
    assign pulse     = event_r;

    // Metastability synchroniser for the raw pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce, first event and repeat; repeat keys off the synced pin so release cuts it at once
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r    <= 1'b0;
            event_r    <= 1'b0;
            db_cnt_r   <= {DB_W{1'b0}};
            rp_cnt_r   <= {RP_W{1'b0}};
            rp_armed_r <= 1'b0;
        end else begin
            event_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    level_r  <= sync2_r;
                    db_cnt_r <= {DB_W{1'b0}};
                    event_r  <= sync2_r;
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= {DB_W{1'b0}};
            end

            if (level_r && sync2_r) begin
                if (rp_cnt_r == rp_last_s) begin
                    event_r    <= 1'b1;
                    rp_cnt_r   <= {RP_W{1'b0}};
                    rp_armed_r <= 1'b1;
                end else begin
                    rp_cnt_r <= rp_cnt_r + RP_W'(1);
                end
            end else begin
                rp_cnt_r   <= {RP_W{1'b0}};
                rp_armed_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day core: BCD hh:mm:ss with a run-gated prescaler, three adjust buttons
// and a registered 12h/24h hour display.
module clock_timekeeper
    import clock_timekeeper_pkg::*;
#(
    parameter int CLK_HZ            = 31_500_000,
    parameter int DEBOUNCE_CYC      = CLK_HZ / 100,
    parameter int REPEAT_DELAY_CYC  = CLK_HZ / 2,
    parameter int REPEAT_PERIOD_CYC = CLK_HZ / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adj_hrs,
    input  logic             adj_min,
    input  logic             adj_sec,
    input  logic             run,
    input  logic             mode_12h,
    output logic [HRS_W-1:0] hrs_bcd,
    output logic [MIN_W-1:0] min_bcd,
    output logic [SEC_W-1:0] sec_bcd,
    output logic             pm,
    output logic             sec_tick
);

    localparam int                PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_next_s;
    logic [HRS_W-1:0]   hrs_r;
    logic [MIN_W-1:0]   min_r;
    logic [SEC_W-1:0]   sec_r;
    logic [HRS_W-1:0]   hrs_next_s;
    logic [MIN_W-1:0]   min_next_s;
    logic [SEC_W-1:0]   sec_next_s;
    logic [HRS_W-1:0]   hrs_bcd_r;
    logic               pm_r;
    logic               sec_tick_r;
    logic [8:0]         sec_inc_s;
    logic [8:0]         min_inc_s;
    logic [8:0]         hrs_inc_s;
    logic               wrap_s;
    logic               tick_s;
    logic               min_carry_s;
    logic               hrs_carry_s;
    logic               hrs_ev_s;
    logic               min_ev_s;
    logic               sec_ev_s;
    logic               unused_bits_s;

    adj_button #(
        .DEBOUNCE_CYC     (DEBOUNCE_CYC),
        .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
        .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
    ) u_btn_hrs (.clk(clk), .reset(reset), .btn(adj_hrs), .pulse(hrs_ev_s));

    adj_button #(
        .DEBOUNCE_CYC     (DEBOUNCE_CYC),
        .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
        .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
    ) u_btn_min (.clk(clk), .reset(reset), .btn(adj_min), .pulse(min_ev_s));

    adj_button #(
        .DEBOUNCE_CYC     (DEBOUNCE_CYC),
        .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
        .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
    ) u_btn_sec (.clk(clk), .reset(reset), .btn(adj_sec), .pulse(sec_ev_s));

    // Next-state time; an adjusted field takes its own +1 and ignores any incoming carry
    always_comb begin
        sec_inc_s   = bcd_inc({1'b0, sec_r}, SEC_MAX);
        min_inc_s   = bcd_inc({1'b0, min_r}, MIN_MAX);
        hrs_inc_s   = bcd_inc({2'b00, hrs_r}, HRS_MAX);
        wrap_s      = run && (presc_r == PRESC_LAST);
        tick_s      = wrap_s && !sec_ev_s;
        min_carry_s = tick_s && sec_inc_s[8];
        hrs_carry_s = min_carry_s && min_inc_s[8];

        if (sec_ev_s || wrap_s) begin
            presc_next_s = {PRESC_W{1'b0}};
        end else if (run) begin
            presc_next_s = presc_r + PRESC_W'(1);
        end else begin
            presc_next_s = presc_r;
        end

        if (sec_ev_s) begin
            sec_next_s = 7'h00;
        end else if (tick_s) begin
            sec_next_s = sec_inc_s[6:0];
        end else begin
            sec_next_s = sec_r;
        end

        if (min_ev_s || min_carry_s) begin
            min_next_s = min_inc_s[6:0];
        end else begin
            min_next_s = min_r;
        end

        if (hrs_ev_s || hrs_carry_s) begin
            hrs_next_s = hrs_inc_s[5:0];
        end else begin
            hrs_next_s = hrs_r;
        end
    end

    assign unused_bits_s = ^{sec_inc_s[7], min_inc_s[7], hrs_inc_s[7:6]};

    // Time state plus display registers, all loaded from the same next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r    <= {PRESC_W{1'b0}};
            hrs_r      <= 6'h00;
            min_r      <= 7'h00;
            sec_r      <= 7'h00;
            hrs_bcd_r  <= 6'h00;
            pm_r       <= 1'b0;
            sec_tick_r <= 1'b0;
        end else begin
            presc_r    <= presc_next_s;
            hrs_r      <= hrs_next_s;
            min_r      <= min_next_s;
            sec_r      <= sec_next_s;
            hrs_bcd_r  <= mode_12h ? to_12h(hrs_next_s) : hrs_next_s;
            pm_r       <= (hrs_next_s >= 6'h12);
            sec_tick_r <= tick_s;
        end
    end

    assign hrs_bcd  = hrs_bcd_r;
    assign min_bcd  = min_r;
    assign sec_bcd  = sec_r;
    assign pm       = pm_r;
    assign sec_tick = sec_tick_r;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper with small timing parameters.
module tb_clock_timekeeper;

    localparam int F_HRS  = 0;
    localparam int F_MIN  = 1;
    localparam int F_SEC  = 2;
    localparam int F_PM   = 3;
    localparam int F_TICK = 4;

    typedef struct {
        int due;
        int field;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       adj_hrs;
    logic       adj_min;
    logic       adj_sec;
    logic       run;
    logic       mode_12h;
    logic [5:0] hrs_bcd;
    logic [6:0] min_bcd;
    logic [6:0] sec_bcd;
    logic       pm;
    logic       sec_tick;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    clock_timekeeper #(
        .CLK_HZ           (10),
        .DEBOUNCE_CYC     (4),
        .REPEAT_DELAY_CYC (20),
        .REPEAT_PERIOD_CYC(5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .adj_hrs (adj_hrs),
        .adj_min (adj_min),
        .adj_sec (adj_sec),
        .run     (run),
        .mode_12h(mode_12h),
        .hrs_bcd (hrs_bcd),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .pm      (pm),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int due, input int field, input int val);
        exp_t e;
        e.due   = due;
        e.field = field;
        e.val   = val;
        sb_q.push_back(e);
    endtask

    task automatic push_reset_state(input int due);
        push(due, F_HRS, 0);
        push(due, F_MIN, 0);
        push(due, F_SEC, 0);
        push(due, F_PM, 0);
        push(due, F_TICK, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    // Cycle offset (from driving the pin) at which the i-th event of a held button shows
    function automatic int vis(input int i);
        return (i == 1) ? 7 : 27 + 5 * (i - 2);
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_HRS:   return "hrs_bcd";
            F_MIN:   return "min_bcd";
            F_SEC:   return "sec_bcd";
            F_PM:    return "pm";
            default: return "sec_tick";
        endcase
    endfunction

    function automatic int dut_field(input int f);
        case (f)
            F_HRS:   return int'(hrs_bcd);
            F_MIN:   return int'(min_bcd);
            F_SEC:   return int'(sec_bcd);
            F_PM:    return int'(pm);
            default: return int'(sec_tick);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                chk($sformatf("%s@%0d", fname(sb_q[i].field), cyc),
                    dut_field(sb_q[i].field), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        int t0;
        int m0;

        reset    = 1'b1;
        adj_hrs  = 1'b0;
        adj_min  = 1'b0;
        adj_sec  = 1'b0;
        run      = 1'b0;
        mode_12h = 1'b1;
        step(3);

        // Reset values, 12h hour right after reset, then 600 cycles of free-running time
        t0 = cyc;
        push_reset_state(t0);
        push(t0 + 1, F_HRS, 'h12);
        push(t0 + 2, F_HRS, 'h00);
        for (int i = 1; i <= 600; i++) begin
            push(t0 + i, F_TICK, (i % 10 == 0) ? 1 : 0);
            if (i % 10 == 0) push(t0 + i, F_SEC, bcd((i / 10) % 60));
        end
        push(t0 + 599, F_MIN, 'h00);
        push(t0 + 599, F_SEC, 'h59);
        push(t0 + 600, F_MIN, 'h01);
        reset = 1'b0;
        run   = 1'b1;
        step(1);
        mode_12h = 1'b0;
        step(599);

        // Preload 23:59 by holding both adjusts with time frozen
        reset = 1'b1;
        run   = 1'b0;
        step(2);
        t0 = cyc;
        push_reset_state(t0);
        for (int i = 1; i <= 23; i++) begin
            push(t0 + vis(i) - 1, F_HRS, bcd(i - 1));
            push(t0 + vis(i), F_HRS, bcd(i));
        end
        for (int i = 1; i <= 59; i++) begin
            push(t0 + vis(i) - 1, F_MIN, bcd(i - 1));
            push(t0 + vis(i), F_MIN, bcd(i));
        end
        push(t0 + vis(11), F_PM, 0);
        push(t0 + vis(12), F_PM, 1);
        push(t0 + 330, F_HRS, 'h23);
        push(t0 + 330, F_MIN, 'h59);
        reset   = 1'b0;
        adj_hrs = 1'b1;
        adj_min = 1'b1;
        step(vis(23) + 1);
        adj_hrs = 1'b0;
        step(vis(59) - vis(23));
        adj_min = 1'b0;
        step(20);

        // Run to 23:59:59 and across midnight
        m0 = cyc;
        push(m0 + 10, F_TICK, 1);
        push(m0 + 10, F_SEC, 'h01);
        push(m0 + 599, F_HRS, 'h23);
        push(m0 + 599, F_MIN, 'h59);
        push(m0 + 599, F_SEC, 'h59);
        push(m0 + 599, F_PM, 1);
        push(m0 + 599, F_TICK, 0);
        push(m0 + 600, F_HRS, 'h00);
        push(m0 + 600, F_MIN, 'h00);
        push(m0 + 600, F_SEC, 'h00);
        push(m0 + 600, F_PM, 0);
        push(m0 + 600, F_TICK, 1);
        push(m0 + 601, F_HRS, 'h12);
        push(m0 + 601, F_PM, 0);
        push(m0 + 602, F_HRS, 'h00);
        run = 1'b1;
        step(600);
        mode_12h = 1'b1;
        step(1);
        mode_12h = 1'b0;
        run      = 1'b0;
        step(2);

        // A 3-cycle glitch on adj_min is rejected
        t0 = cyc;
        for (int i = 1; i <= 20; i++) push(t0 + i, F_MIN, 'h00);
        adj_min = 1'b1;
        step(3);
        adj_min = 1'b0;
        step(17);

        // Clean hold: events at 7, 27, 32, 37; release stops the repeat
        t0 = cyc;
        push(t0 + 6, F_MIN, 'h00);
        push(t0 + 7, F_MIN, 'h01);
        push(t0 + 26, F_MIN, 'h01);
        push(t0 + 27, F_MIN, 'h02);
        push(t0 + 31, F_MIN, 'h02);
        push(t0 + 32, F_MIN, 'h03);
        push(t0 + 36, F_MIN, 'h03);
        push(t0 + 37, F_MIN, 'h04);
        for (int i = 38; i <= 60; i++) push(t0 + i, F_MIN, 'h04);
        adj_min = 1'b1;
        step(38);
        adj_min = 1'b0;
        step(25);

        // adj_sec while frozen zeroes seconds and prescaler
        t0 = cyc;
        push(t0 + 7, F_SEC, 'h00);
        push(t0 + 7, F_MIN, 'h04);
        adj_sec = 1'b1;
        step(8);
        adj_sec = 1'b0;
        step(10);

        // adj_sec landing on a prescaler wrap suppresses that tick
        t0 = cyc;
        for (int i = 1; i <= 40; i++) push(t0 + i, F_TICK, (i == 10 || i == 20 || i == 40) ? 1 : 0);
        push(t0 + 10, F_SEC, 'h01);
        push(t0 + 20, F_SEC, 'h02);
        push(t0 + 29, F_SEC, 'h02);
        push(t0 + 30, F_SEC, 'h00);
        push(t0 + 39, F_SEC, 'h00);
        push(t0 + 40, F_SEC, 'h01);
        run = 1'b1;
        step(23);
        adj_sec = 1'b1;
        step(8);
        adj_sec = 1'b0;
        step(12);
        run = 1'b0;
        step(2);

        // Hour 12 in both modes, then 13 shown as 01 after switching to 12h
        t0 = cyc;
        for (int i = 1; i <= 11; i++) push(t0 + vis(i), F_HRS, bcd(i));
        push(t0 + 76, F_HRS, 'h11);
        push(t0 + 76, F_PM, 0);
        push(t0 + 77, F_HRS, 'h12);
        push(t0 + 77, F_PM, 1);
        push(t0 + 78, F_HRS, 'h12);
        push(t0 + 79, F_HRS, 'h12);
        push(t0 + 79, F_PM, 1);
        push(t0 + 80, F_HRS, 'h12);
        push(t0 + 82, F_HRS, 'h13);
        push(t0 + 82, F_PM, 1);
        push(t0 + 84, F_HRS, 'h13);
        push(t0 + 85, F_HRS, 'h01);
        push(t0 + 85, F_PM, 1);
        push(t0 + 86, F_HRS, 'h01);
        push(t0 + 88, F_HRS, 'h13);
        adj_hrs = 1'b1;
        step(78);
        mode_12h = 1'b1;
        step(1);
        mode_12h = 1'b0;
        step(4);
        adj_hrs = 1'b0;
        step(1);
        mode_12h = 1'b1;
        step(3);
        mode_12h = 1'b0;
        step(2);

        // Freeze for 37 cycles mid-second; the second completes after the remaining counts
        adj_sec = 1'b1;
        step(8);
        adj_sec = 1'b0;
        step(10);
        t0 = cyc;
        for (int i = 1; i <= 47; i++) push(t0 + i, F_TICK, (i == 47) ? 1 : 0);
        push(t0 + 46, F_SEC, 'h00);
        push(t0 + 47, F_SEC, 'h01);
        push(t0 + 47, F_HRS, 'h13);
        run = 1'b1;
        step(4);
        run = 1'b0;
        step(37);
        run = 1'b1;
        step(8);

        // Reset during a held adj_hrs; a fresh event follows 6 cycles after release
        t0 = cyc;
        push(t0 + 6, F_HRS, 'h13);
        push(t0 + 7, F_HRS, 'h14);
        for (int i = 16; i <= 18; i++) push_reset_state(t0 + i);
        push(t0 + 19, F_HRS, 'h00);
        push(t0 + 19, F_PM, 0);
        push(t0 + 24, F_HRS, 'h00);
        push(t0 + 25, F_HRS, 'h01);
        push(t0 + 27, F_TICK, 0);
        push(t0 + 28, F_TICK, 1);
        push(t0 + 28, F_SEC, 'h01);
        push(t0 + 50, F_HRS, 'h01);
        adj_hrs = 1'b1;
        step(15);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(8);
        adj_hrs = 1'b0;
        step(30);

        chk("sb_left", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
